// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter for a single-port registered-read RAM
// Fixed priority to A with a B starvation guard; define RAM_ARB_RR_EN for round-robin.
module ram_arbiter #(
  parameter int WORD         = 1,
  parameter int SIZE_LOG     = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [SIZE_LOG-1:0] a_addr,
  input  logic [WORD-1:0]     a_wdata,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [WORD-1:0]     a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [SIZE_LOG-1:0] b_addr,
  input  logic [WORD-1:0]     b_wdata,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [WORD-1:0]     b_rdata,
  output logic                ram_read,
  output logic                ram_write,
  output logic [SIZE_LOG-1:0] ram_address,
  output logic [WORD-1:0]     ram_data_in,
  input  logic [WORD-1:0]     ram_data_out
);

  logic                grant_a, grant_b, win_we;
  logic [SIZE_LOG-1:0] win_addr;
  logic [WORD-1:0]     win_wdata;

  logic                ram_read_q, ram_read_d;
  logic                ram_write_q, ram_write_d;
  logic [SIZE_LOG-1:0] ram_address_q, ram_address_d;
  logic [WORD-1:0]     ram_data_in_q, ram_data_in_d;
  logic                rd1_v_q, rd1_v_d;
  logic                rd1_b_q, rd1_b_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;

`ifdef RAM_ARB_RR_EN
  // 1 when A was the most recent winner; reset value lets A win first
  logic rr_last_a_q, rr_last_a_d;
`else
  logic [7:0] starve_q, starve_d;
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
`ifdef RAM_ARB_RR_EN
    if (a_req && b_req) begin
      grant_a = !rr_last_a_q;
      grant_b = rr_last_a_q;
    end else begin
      grant_a = a_req;
      grant_b = b_req;
    end
`else
    if (b_req && (!a_req || starve_q == 8'(STARVE_LIMIT))) begin
      grant_b = 1'b1;
    end else begin
      grant_a = a_req;
    end
`endif
    if (!rst_n) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  always_comb begin
    win_we    = grant_b ? b_we    : a_we;
    win_addr  = grant_b ? b_addr  : a_addr;
    win_wdata = grant_b ? b_wdata : a_wdata;

    ram_read_d    = 1'b0;
    ram_write_d   = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    if (grant_a || grant_b) begin
      ram_read_d    = !win_we;
      ram_write_d   = win_we;
      ram_address_d = win_addr;
      ram_data_in_d = win_wdata;
    end

    // Owner pipeline: stage 1 rides with the RAM command, stage 2 with the returned data
    rd1_v_d    = (grant_a || grant_b) && !win_we;
    rd1_b_d    = grant_b;
    a_rvalid_d = rd1_v_q && !rd1_b_q;
    b_rvalid_d = rd1_v_q && rd1_b_q;

`ifdef RAM_ARB_RR_EN
    rr_last_a_d = rr_last_a_q;
    if (grant_a) begin
      rr_last_a_d = 1'b1;
    end else if (grant_b) begin
      rr_last_a_d = 1'b0;
    end
`else
    starve_d = 8'd0;
    if (b_req && !grant_b) begin
      starve_d = (starve_q == 8'(STARVE_LIMIT)) ? starve_q : starve_q + 8'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_read_q    <= 1'b0;
      ram_write_q   <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      rd1_v_q       <= 1'b0;
      rd1_b_q       <= 1'b0;
      a_rvalid_q    <= 1'b0;
      b_rvalid_q    <= 1'b0;
`ifdef RAM_ARB_RR_EN
      rr_last_a_q   <= 1'b0;
`else
      starve_q      <= 8'd0;
`endif
    end else begin
      ram_read_q    <= ram_read_d;
      ram_write_q   <= ram_write_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      rd1_v_q       <= rd1_v_d;
      rd1_b_q       <= rd1_b_d;
      a_rvalid_q    <= a_rvalid_d;
      b_rvalid_q    <= b_rvalid_d;
`ifdef RAM_ARB_RR_EN
      rr_last_a_q   <= rr_last_a_d;
`else
      starve_q      <= starve_d;
`endif
    end
  end

  assign a_gnt       = grant_a;
  assign b_gnt       = grant_b;
  assign ram_read    = ram_read_q;
  assign ram_write   = ram_write_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rvalid_q ? ram_data_out : '0;
  assign b_rdata     = b_rvalid_q ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter (default fixed-priority build)
module tb_ram_arbiter;
  localparam int WORD         = 1;
  localparam int SIZE_LOG     = 8;
  localparam int STARVE_LIMIT = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                a_req, a_we, a_gnt, a_rvalid;
  logic [SIZE_LOG-1:0] a_addr;
  logic [WORD-1:0]     a_wdata, a_rdata;
  logic                b_req, b_we, b_gnt, b_rvalid;
  logic [SIZE_LOG-1:0] b_addr;
  logic [WORD-1:0]     b_wdata, b_rdata;
  logic                ram_read, ram_write;
  logic [SIZE_LOG-1:0] ram_address;
  logic [WORD-1:0]     ram_data_in, ram_data_out;

  ram_arbiter #(.WORD(WORD), .SIZE_LOG(SIZE_LOG), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read
  logic [WORD-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_write) mem[ram_address] <= ram_data_in;
    if (ram_read) ram_data_out <= mem[ram_address];
  end

  typedef struct {
    int       due;
    bit       port_b;
    logic     dat;
  } ret_t;

  typedef struct {
    logic       ar, aw;
    logic [7:0] aa;
    logic       ad;
    logic       br, bw;
    logic [7:0] ba;
    logic       bd;
    logic       ea, eb;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         b_wait = 0;
  logic       ref_mem [256];
  logic       exp_rd = 1'b0, exp_wr = 1'b0, exp_din = 1'b0;
  logic [7:0] exp_addr = 8'd0;
  ret_t       rq[$];
  logic       last_ga = 1'b0, last_gb = 1'b0;
  logic       s_a_gnt, s_b_gnt, s_a_rvalid, s_b_rvalid, s_a_rdata, s_b_rdata;
  logic       s_ram_read, s_ram_write;
  vec_t       tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: sample and compare at negedge, then advance the reference model
  task automatic cycle();
    logic ea, eb, e_av, e_bv, e_ad, e_bd, we, wd;
    logic [7:0] ad;
    ret_t r;
    @(negedge clk);
    ea = 1'b0;
    eb = 1'b0;
    if (rst_n) begin
      if (b_req && (!a_req || b_wait >= STARVE_LIMIT)) eb = 1'b1;
      else if (a_req) ea = 1'b1;
    end
    s_a_gnt = a_gnt; s_b_gnt = b_gnt;
    s_a_rvalid = a_rvalid; s_b_rvalid = b_rvalid;
    s_a_rdata = a_rdata; s_b_rdata = b_rdata;
    s_ram_read = ram_read; s_ram_write = ram_write;
    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    chk("ram_read", ram_read, exp_rd);
    chk("ram_write", ram_write, exp_wr);
    chk("ram_address", ram_address, exp_addr);
    chk("ram_data_in", ram_data_in, exp_din);
    e_av = 1'b0; e_bv = 1'b0; e_ad = 1'b0; e_bd = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.port_b) begin e_bv = 1'b1; e_bd = r.dat; end
      else begin e_av = 1'b1; e_ad = r.dat; end
    end
    chk("a_rvalid", a_rvalid, e_av);
    chk("b_rvalid", b_rvalid, e_bv);
    chk("a_rdata", a_rdata, e_ad);
    chk("b_rdata", b_rdata, e_bd);
    if (!rst_n) begin
      exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = 8'd0; exp_din = 1'b0;
      rq.delete();
      b_wait = 0;
    end else begin
      exp_rd = 1'b0;
      exp_wr = 1'b0;
      if (ea || eb) begin
        we = eb ? b_we : a_we;
        ad = eb ? b_addr : a_addr;
        wd = eb ? b_wdata : a_wdata;
        exp_rd = !we; exp_wr = we; exp_addr = ad; exp_din = wd;
        if (we) ref_mem[ad] = wd;
        else rq.push_back('{due: cyc + 2, port_b: eb, dat: ref_mem[ad]});
      end
      if (b_req && !eb) b_wait = (b_wait < STARVE_LIMIT) ? b_wait + 1 : b_wait;
      else b_wait = 0;
    end
    last_ga = ea;
    last_gb = eb;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(logic ar, logic aw, logic [7:0] aa, logic ad,
                             logic br, logic bw, logic [7:0] ba, logic bd,
                             logic ea, logic eb);
    vec_t t;
    t.ar = ar; t.aw = aw; t.aa = aa; t.ad = ad;
    t.br = br; t.bw = bw; t.ba = ba; t.bd = bd;
    t.ea = ea; t.eb = eb;
    return t;
  endfunction

  task automatic idle();
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 1'($urandom_range(0, 1));
      ref_mem[i] = mem[i];
    end
    mem[8'h01] = 1'b0; ref_mem[8'h01] = 1'b0;
    mem[8'h02] = 1'b1; ref_mem[8'h02] = 1'b1;
    mem[8'h10] = 1'b0; ref_mem[8'h10] = 1'b0;
    mem[8'h11] = 1'b0; ref_mem[8'h11] = 1'b0;
    mem[8'h20] = 1'b1; ref_mem[8'h20] = 1'b1;

    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h05; a_wdata = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20; b_wdata = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b1;

    // Starvation guard pattern, write-then-read, lone B, and counter clear on B withdrawal
    for (int i = 0; i < 10; i++)
      tbl.push_back(v(1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0,
                      (i % 5) != 4, (i % 5) == 4));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b1, 1'b1, 8'h30, 1'b1, 1'b1, 1'b1, 8'h31, 1'b1, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h31, 1'b1, 1'b0, 1'b1));
    tbl.push_back(v(1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0, i != 4, i == 4));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      a_req = tbl[i].ar; a_we = tbl[i].aw; a_addr = tbl[i].aa; a_wdata = tbl[i].ad;
      b_req = tbl[i].br; b_we = tbl[i].bw; b_addr = tbl[i].ba; b_wdata = tbl[i].bd;
      cycle();
      chk("tbl_a_gnt", s_a_gnt, tbl[i].ea);
      chk("tbl_b_gnt", s_b_gnt, tbl[i].eb);
    end

    // A write 0x11=1 then read it back on the next cycle
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h11; a_wdata = 1'b1; b_req = 1'b0;
    cycle();
    a_we = 1'b0;
    cycle();
    chk("seq_wr_ram_write", s_ram_write, 1'b1);
    idle();
    cycle();
    chk("seq_rd_ram_read", s_ram_read, 1'b1);
    cycle();
    chk("seq_a_rvalid", s_a_rvalid, 1'b1);
    chk("seq_a_rdata", s_a_rdata, 1'b1);
    chk("seq_b_rvalid", s_b_rvalid, 1'b0);

    // Read accepted, then reset in the following cycle: nothing returns
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h02;
    cycle();
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_a_rvalid", s_a_rvalid, 1'b0);
      chk("rst_b_rvalid", s_b_rvalid, 1'b0);
      chk("rst_ram_read", s_ram_read, 1'b0);
    end

    // Lone B reads 0x01 then 0x02, back to back
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h01;
    cycle();
    chk("solo_b_gnt0", s_b_gnt, 1'b1);
    b_addr = 8'h02;
    cycle();
    chk("solo_b_gnt1", s_b_gnt, 1'b1);
    idle();
    cycle();
    chk("solo_b_rvalid0", s_b_rvalid, 1'b1);
    chk("solo_b_rdata0", s_b_rdata, 1'b0);
    cycle();
    chk("solo_b_rvalid1", s_b_rvalid, 1'b1);
    chk("solo_b_rdata1", s_b_rdata, 1'b1);

    // Randomized traffic with requests held until granted and occasional resets
    for (int i = 0; i < 600; i++) begin
      if (!a_req || last_ga) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_we = 1'($urandom_range(0, 1));
        a_addr = 8'($urandom_range(0, 15));
        a_wdata = 1'($urandom_range(0, 1));
      end
      if (!b_req || last_gb) begin
        b_req = ($urandom_range(0, 2) != 0);
        b_we = 1'($urandom_range(0, 1));
        b_addr = 8'($urandom_range(0, 15));
        b_wdata = 1'($urandom_range(0, 1));
      end
      rst_n = ($urandom_range(0, 79) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-port arbiter in front of the single-port 1-bit data RAM (registered read, 1-cycle latency). Port A is the MC14500B core data access; port B is the host/debug/loader access. The block accepts one request per cycle, drives registered RAM commands, and steers read data back to the issuing port with a valid strobe. Default scheduling is fixed priority to A with a starvation guard for B.

Parameters:
WORD, 1, RAM data width in bits
SIZE_LOG, 8, RAM address width
STARVE_LIMIT, 4, consecutive cycles B may be refused before it is forced through; legal range 1..255

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset
a_req  input  1  port A request; held with a_we/a_addr/a_wdata stable until a_gnt
a_we  input  1  port A: 1 = write, 0 = read
a_addr  input  SIZE_LOG  port A address
a_wdata  input  WORD  port A write data
a_gnt  output  1  port A request accepted this cycle (combinational)
a_rvalid  output  1  port A read data valid (registered)
a_rdata  output  WORD  port A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
ram_read  output  1  RAM read enable (registered)
ram_write  output  1  RAM write enable (registered)
ram_address  output  SIZE_LOG  RAM address (registered)
ram_data_in  output  WORD  RAM write data (registered)
ram_data_out  input  WORD  RAM registered read data

Behaviour:
- Reset (rst_n low at posedge): ram_read, ram_write, ram_address, ram_data_in, a_rvalid, b_rvalid, starvation counter, RR pointer all 0. a_gnt/b_gnt forced 0 while rst_n low. In-flight reads discarded; no rvalid after reset deassert for a pre-reset request.
- Acceptance: at most one gnt per cycle; gnt asserted only if matching req high. Transfer occurs in cycle N when req && gnt.
- Issue: accepted command registered at end of cycle N; ram_read = !we, ram_write = we, ram_address/ram_data_in from winner, valid during cycle N+1. Cycle with no grant: ram_read = ram_write = 0, ram_address/ram_data_in hold last value.
- Read return: RAM captures at end of N+1; x_rvalid high for exactly one cycle in N+2 for the issuing port; x_rdata = ram_data_out while x_rvalid, else 0. Two-stage owner pipeline (valid + port-id) tracks in-flight reads. Writes produce no rvalid.
- Throughput: one access per cycle, back-to-back; reads from different ports interleave without bubbles, returned in issue order.
- Ordering: write in cycle N then read same address in N+1 returns new data (RAM write at end of N+1, read at end of N+2).
- Fixed priority (default): A wins when a_req high unless starve flag set. Starvation counter increments each cycle b_req && !b_gnt, saturating at STARVE_LIMIT; when counter == STARVE_LIMIT, B wins next arbitration regardless of a_req. Counter clears on b_gnt or when b_req low.
- Request withdrawn before gnt: allowed, no effect.
- Only one request: it is granted the same cycle (no idle bubble).

Optional Feature:
RAM_ARB_RR_EN: defined -> round-robin; single-bit last-winner pointer, when both request the port not granted last wins; pointer updates only on grant; starvation counter and STARVE_LIMIT unused (counter held 0). Undefined -> fixed priority A with starvation guard as above.

Test Plan:
- Reset: rst_n low 3 cycles with a_req=b_req=1 -> no gnt, ram_read=ram_write=0, rvalids 0; release -> a_gnt in first cycle.
- A write addr 0x10 data 1 in cycle N, A read 0x10 in N+1 -> ram_write at N+1, ram_read at N+2, a_rvalid=1, a_rdata=1 at N+3, b_rvalid stays 0.
- Both req continuous, fixed priority, STARVE_LIMIT=4 -> a_gnt 4 cycles, b_gnt in 5th, pattern repeats; B reads addr 0x20 return on b_rvalid only.
- RAM_ARB_RR_EN, both req continuous -> gnt alternates A,B,A,B; interleaved reads of 0x01(=0)/0x02(=1) return 0/1 on correct ports in order.
- Read accepted, rst_n low in following cycle -> no rvalid on either port afterwards; ram_read 0.
- Single B request, a_req=0 -> b_gnt same cycle, b_rvalid 2 cycles later with stored value.
